piso_shift_tx: RTL and testbench

PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

---
 rtl/piso_shift_tx.sv | 98 +++++++++
 tb/tb_piso_shift_tx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: MSB-first frame of WIDTH bits (plus even parity when PISO_SHIFT_TX_PARITY_EN is defined).
// Latency: first bit on q the cycle after load&ready; done marks the last frame bit; one idle cycle between frames.
// Backpressure: ready is high only in IDLE; load is ignored while a frame is shifting out.
module piso_shift_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             q,
  output logic             q_valid,
  output logic             done
);

`ifdef PISO_SHIFT_TX_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [FL-1:0] r_shift;
  logic [CW-1:0] r_cnt;
  logic [FL-1:0] w_frame;
  logic          w_last;
  logic          w_accept;

`ifdef PISO_SHIFT_TX_PARITY_EN
  // Even parity: the appended bit makes the frame's total count of ones even.
  assign w_frame = {din, ^din};
`else
  assign w_frame = din;
`endif

  assign w_last = (r_cnt == CW'(FL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Outputs decode from registered state only, so reset clears them without a clock edge.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    ready       = 1'b0;
    q           = 1'b0;
    q_valid     = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (load) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        q       = r_shift[FL-1];
        q_valid = 1'b1;
        done    = w_last;
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_shift <= w_frame;
      r_cnt   <= '0;
    end else if (r_state == S_SHIFT) begin
      r_shift <= {r_shift[FL-2:0], 1'b0};
      // Counter parks at zero after the last bit rather than wrapping.
      r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx (WIDTH=4); expected frames follow PISO_SHIFT_TX_PARITY_EN.
module tb_piso_shift_tx;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic       load;
  logic       ready;
  logic       q;
  logic       q_valid;
  logic       done;

  int n_chk = 0;
  int n_err = 0;

`ifdef PISO_SHIFT_TX_PARITY_EN
  localparam int FL = 5;
  localparam logic [4:0] E_1011 = 5'b10111;
  localparam logic [4:0] E_1001 = 5'b10010;
  localparam logic [4:0] E_1100 = 5'b11000;
  localparam logic [4:0] E_1010 = 5'b10100;
  localparam logic [4:0] E_0110 = 5'b01100;
  localparam logic [4:0] E_1111 = 5'b11110;
  localparam logic [4:0] E_0000 = 5'b00000;
`else
  localparam int FL = 4;
  localparam logic [4:0] E_1011 = 5'b01011;
  localparam logic [4:0] E_1001 = 5'b01001;
  localparam logic [4:0] E_1100 = 5'b01100;
  localparam logic [4:0] E_1010 = 5'b01010;
  localparam logic [4:0] E_0110 = 5'b00110;
  localparam logic [4:0] E_1111 = 5'b01111;
  localparam logic [4:0] E_0000 = 5'b00000;
`endif

  piso_shift_tx #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .load    (load),
    .ready   (ready),
    .q       (q),
    .q_valid (q_valid),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".ready"}, ready, 1'b1);
    chk({tag, ".q"}, q, 1'b0);
    chk({tag, ".q_valid"}, q_valid, 1'b0);
    chk({tag, ".done"}, done, 1'b0);
  endtask

  // Checks frame cycle idx (0-based) against the expected bit vector.
  task automatic chk_bit(input string tag, input logic [4:0] exp, input int idx);
    chk($sformatf("%s.q%0d", tag, idx + 1), q, exp[FL-1-idx]);
    chk($sformatf("%s.vld%0d", tag, idx + 1), q_valid, 1'b1);
    chk($sformatf("%s.done%0d", tag, idx + 1), done, (idx == FL - 1));
    chk($sformatf("%s.rdy%0d", tag, idx + 1), ready, 1'b0);
  endtask

  // Starts in IDLE just after an edge; leaves us in the first IDLE cycle after the frame.
  task automatic frame(input string tag, input logic [3:0] w, input logic [4:0] exp);
    din  = w;
    load = 1'b1;
    chk({tag, ".ready0"}, ready, 1'b1);
    step();
    load = 1'b0;
    for (int i = 0; i < FL; i++) begin
      chk_bit(tag, exp, i);
      step();
    end
    chk_idle({tag, ".end"});
  endtask

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    din  = 4'h0;
    #1;
    chk_idle("reset");
    step();
    step();
    rst = 1'b0;
    step();
    chk_idle("post_reset");

    frame("f1011", 4'b1011, E_1011);
    frame("f1001", 4'b1001, E_1001);
    frame("f0000", 4'b0000, E_0000);

    // Load pulse mid-frame with a new din must not disturb the frame.
    din  = 4'b1100;
    load = 1'b1;
    step();
    load = 1'b0;
    chk_bit("ign", E_1100, 0);
    din  = 4'b0011;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 1; i < FL; i++) begin
      chk_bit("ign", E_1100, i);
      step();
    end
    chk_idle("ign.gap1");
    step();
    chk_idle("ign.gap2");

    // Continuous load: exactly one idle cycle between frames.
    din  = 4'b1010;
    load = 1'b1;
    step();
    for (int i = 0; i < FL; i++) begin
      chk_bit("b2b_a", E_1010, i);
      din = 4'b0110;
      step();
    end
    chk_idle("b2b.gap");
    step();
    for (int i = 0; i < FL; i++) begin
      chk_bit("b2b_b", E_0110, i);
      load = 1'b0;
      step();
    end
    chk_idle("b2b.end");

    // Asynchronous reset during bit 2 aborts the frame.
    din  = 4'b1111;
    load = 1'b1;
    step();
    load = 1'b0;
    chk_bit("rst", E_1111, 0);
    step();
    chk_bit("rst", E_1111, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("rst.async");
    load = 1'b1;
    step();
    chk_idle("rst.load_held");
    load = 1'b0;
    rst  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_idle($sformatf("rst.after%0d", i));
    end

    frame("f1011_again", 4'b1011, E_1011);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #20000;
    n_err++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "timeout");
  end

endmodule
